simple_bus_arb_mem: RTL and testbench
=====================================

SIMPLE_BUS_ARB_MEM -- requirements
Module: simple_bus_arb_mem

Interface
REQ-001 SHALL take parameter N_MASTERS, default 2: number of master ports (1..8).
REQ-002 SHALL take parameter AW, default 8: address width.
REQ-003 SHALL take parameter DW, default 8: data width.
REQ-004 SHALL take parameter DEPTH, default 256: memory words; DEPTH <= 2**AW.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port req, input, N_MASTERS: per-master bus request.
REQ-008 SHALL have port gnt, output, N_MASTERS: per-master grant, one-hot or zero.
REQ-009 SHALL have port start, input, N_MASTERS: per-master transfer-start pulse.
REQ-010 SHALL have port mode, input, 2*N_MASTERS: per-master mode; 2'b00 is read, 2'b01 is write, others are invalid.
REQ-011 SHALL have port addr, input, AW*N_MASTERS: per-master address, master i in slice [i*AW +: AW].
REQ-012 SHALL have port wdata, input, DW*N_MASTERS: per-master write data.
REQ-013 SHALL have port rdata, output, DW: read data, shared by all masters.
REQ-014 SHALL have port rdy, output, N_MASTERS: per-master completion pulse.
REQ-015 SHALL have port err, output, 1: error pulse, coincident with rdy.

Function
REQ-016 SHALL implement an FSM with states IDLE, GRANT, ACCESS and RESP.
REQ-017 IDLE: when any req bit is high, SHALL select the winner round-robin, starting the search at pointer ptr, then move to GRANT with gnt[winner]=1 on the next cycle.
REQ-018 Request-to-grant latency SHALL be 1 cycle.
REQ-019 GRANT: start[winner]=1 SHALL capture addr, mode and wdata of the winner and move to ACCESS.
REQ-020 GRANT: start on a non-granted master SHALL be ignored.
REQ-021 GRANT: if req[winner] drops before start, SHALL clear gnt, return to IDLE and leave ptr unchanged.
REQ-022 ACCESS: a write SHALL store wdata at addr; a read SHALL register mem[addr] into rdata.
REQ-023 RESP: SHALL pulse rdy[winner] for exactly 1 cycle.
REQ-024 rdata SHALL stay valid from RESP until the next read completes.
REQ-025 Start-to-rdy latency SHALL be 2 cycles.
REQ-026 RESP: gnt SHALL deassert on the cycle after RESP.
REQ-027 RESP: ptr SHALL become (winner+1) mod N_MASTERS.
REQ-028 RESP: the FSM SHALL return to IDLE, so a master holding req re-arbitrates.
REQ-029 Invalid mode, or addr >= DEPTH, SHALL perform no memory write and leave rdata unchanged.
REQ-030 Invalid mode, or addr >= DEPTH, SHALL still pulse rdy, with err=1 in the same cycle.
REQ-031 gnt SHALL be asserted from GRANT through RESP inclusive, and low otherwise.
REQ-032 When N_MASTERS=1, arbitration SHALL degenerate to a fixed grant, with no behaviour change otherwise.
REQ-033 Memory contents SHALL persist across transactions and SHALL NOT be cleared by reset.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, gnt=0, rdy=0, err=0, rdata=0 and ptr=0, independent of clk.
REQ-035 Reset asserted mid-transaction SHALL abort it; a write in ACCESS during reset assertion is undefined and must not be relied on.
REQ-036 After rst_n rises, the first arbitration SHALL occur on the first clk edge with req high.

Verification
REQ-037 Write then read (N_MASTERS=2): master0 writes 8'hA5 to addr 8'h10; master0 then reads 8'h10 -> rdy0 pulses 2 cycles after each start; rdata=8'hA5; err=0.
REQ-038 Fairness: req=2'b11 held continuously for 4 transactions -> grants alternate 0,1,0,1.
REQ-039 Request withdrawn: master1 gets gnt, drops req without start -> gnt=0 next cycle; the next grant with req=2'b11 goes to master1 again (ptr unchanged).
REQ-040 Error cases: with DEPTH=200, a write to addr 8'd220 -> rdy and err pulse together, and memory is unchanged (a read of addr 8'd220 returns the previous rdata with err=1); mode 2'b10 -> err=1.
REQ-041 Reset mid-operation: assert rst_n=0 during RESP -> rdy, gnt, err and rdata are 0 asynchronously; after release, a new req is granted in 1 cycle.
REQ-042 Stray start: start[1] while master0 is granted -> no effect; the master0 transaction completes normally.

Source files
------------

// File: rtl/simple_bus_arb_mem.sv
// Round-robin arbitrated single-port memory shared by N_MASTERS bus masters.
// A grant is held from GRANT through RESP, and the memory contents survive reset.
module simple_bus_arb_mem #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int DEPTH     = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_MASTERS-1:0]   req,
  output logic [N_MASTERS-1:0]   gnt,
  input  logic [N_MASTERS-1:0]   start,
  input  logic [2*N_MASTERS-1:0] mode,
  input  logic [AW*N_MASTERS-1:0] addr,
  input  logic [DW*N_MASTERS-1:0] wdata,
  output logic [DW-1:0]          rdata,
  output logic [N_MASTERS-1:0]   rdy,
  output logic                   err
);

  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] winner, winner_nxt, ptr, idx;
  logic          found;
  logic [AW-1:0] addr_q;
  logic [1:0]    mode_q;
  logic [DW-1:0] wdata_q;
  logic          mode_ok, in_range, is_write, is_read;

  logic [DW-1:0] mem [DEPTH];

  assign mode_ok  = (mode_q == 2'b00) || (mode_q == 2'b01);
  assign in_range = (32'(addr_q) < DEPTH);
  assign is_write = in_range && (mode_q == 2'b01);
  assign is_read  = in_range && (mode_q == 2'b00);

  // Round-robin search: first requesting master at or after ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    winner_nxt = ptr;
    found      = 1'b0;
    idx        = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = PW'((int'(ptr) + k) % N_MASTERS);
      if (!found && req[idx]) begin
        found      = 1'b1;
        winner_nxt = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      winner <= '0;
      ptr    <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments.
      state <= state_nxt;
      if (state == IDLE && found)
        winner <= winner_nxt;
      if (state == RESP)
        ptr <= PW'((int'(winner) + 1) % N_MASTERS);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   if (start[winner])    state_nxt = ACCESS;
               else if (!req[winner]) state_nxt = IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    gnt = '0;
    rdy = '0;
    err = 1'b0;
    if (state != IDLE)
      gnt[winner] = 1'b1;
    if (state == RESP) begin
      rdy[winner] = 1'b1;
      err         = !(mode_ok && in_range);
    end
  end

  // Transfer capture and read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      mode_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (state == GRANT && start[winner]) begin
        addr_q  <= addr[int'(winner)*AW +: AW];
        mode_q  <= mode[int'(winner)*2 +: 2];
        wdata_q <= wdata[int'(winner)*DW +: DW];
      end
      if (state == ACCESS && is_read)
        rdata <= mem[addr_q];
    end
  end

  // NOTE: the memory array is deliberately not reset; contents persist across rst_n.
  always_ff @(posedge clk) begin
    if (state == ACCESS && is_write)
      mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_simple_bus_arb_mem.sv
// Directed bench for simple_bus_arb_mem (2 masters, DEPTH=200) with a response scoreboard.
module tb_simple_bus_arb_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, gnt, start, rdy;
  logic [3:0]  mode;
  logic [15:0] addr, wdata;
  logic [7:0]  rdata;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         m;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl_mem [256];
  logic [7:0] mdl_rdata;

  simple_bus_arb_mem #(.N_MASTERS(2), .AW(8), .DW(8), .DEPTH(200)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .start(start), .mode(mode),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rdy(rdy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a grant and checks who got it and after how many cycles.
  task automatic wait_gnt(input int m, input int exp_lat, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 2'b00 && n < 8);
    check({tag, "_gnt"}, 32'(gnt), 32'(1 << m));
    check({tag, "_gnt_lat"}, n, exp_lat);
  endtask

  // Issues start for granted master m, then checks the response off the scoreboard.
  task automatic run_txn(input int m, input logic [1:0] md, input logic [7:0] a,
                         input logic [7:0] wd, input string tag);
    exp_t e, got;
    int   n;
    e.m   = m;
    e.err = !((md == 2'b00 || md == 2'b01) && a < 8'd200);
    if (!e.err) begin
      if (md == 2'b01) mdl_mem[a] = wd;
      else             mdl_rdata  = mdl_mem[a];
    end
    e.rdata = mdl_rdata;
    sb.push_back(e);

    mode[2*m +: 2]  = md;
    addr[8*m +: 8]  = a;
    wdata[8*m +: 8] = wd;
    start[m]        = 1'b1;
    @(negedge clk);
    start = 2'b00;
    n = 1;
    while (rdy == 2'b00 && n < 8) begin
      @(negedge clk);
      n++;
    end
    got = sb.pop_front();
    check({tag, "_rdy_lat"}, n, 2);
    check({tag, "_rdy"}, 32'(rdy), 32'(1 << got.m));
    check({tag, "_err"}, 32'(err), 32'(got.err));
    check({tag, "_rdata"}, 32'(rdata), 32'(got.rdata));
    check({tag, "_gnt_resp"}, 32'(gnt), 32'(1 << m));
  endtask

  // Lone-master transaction: request, grant, transfer, release, check idle.
  task automatic single(input int m, input logic [1:0] md, input logic [7:0] a,
                        input logic [7:0] wd, input string tag);
    req[m] = 1'b1;
    wait_gnt(m, 1, tag);
    run_txn(m, md, a, wd, tag);
    req[m] = 1'b0;
    @(negedge clk);
    check({tag, "_gnt_off"}, 32'(gnt), 0);
    check({tag, "_rdy_off"}, 32'(rdy), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 2'b00;
    start     = 2'b00;
    mode      = 4'b1111;
    addr      = 16'hFFFF;
    wdata     = 16'h0000;
    mdl_rdata = 8'h00;
    #1;
    check("reset_gnt", 32'(gnt), 0);
    check("reset_rdy", 32'(rdy), 0);
    check("reset_err", 32'(err), 0);
    check("reset_rdata", 32'(rdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back through master 0.
    single(0, 2'b01, 8'h10, 8'hA5, "wr10");
    single(0, 2'b00, 8'h10, 8'h00, "rd10");

    // Master 1 withdraws its request; ptr must not advance.
    req = 2'b10;
    wait_gnt(1, 1, "wd_first");
    req = 2'b00;
    @(negedge clk);
    check("wd_gnt_drop", 32'(gnt), 0);
    req = 2'b11;
    wait_gnt(1, 1, "wd_again");
    run_txn(1, 2'b01, 8'h20, 8'h3C, "wd_txn");

    // Fairness with both requests held.
    for (int i = 0; i < 4; i++) begin
      wait_gnt(i % 2, 2, $sformatf("fair%0d", i));
      run_txn(i % 2, 2'b01, 8'(8'h30 + i), 8'(8'h50 + i), $sformatf("fair%0d", i));
    end
    req = 2'b00;
    @(negedge clk);
    check("fair_gnt_off", 32'(gnt), 0);

    // Cross-master data and the last valid address.
    single(0, 2'b00, 8'h31, 8'h00, "rd31");
    single(1, 2'b00, 8'h20, 8'h00, "rd20");
    single(1, 2'b01, 8'd199, 8'h99, "wr199");

    // Error responses: out of range and invalid modes.
    single(0, 2'b01, 8'd220, 8'h77, "wr220");
    single(0, 2'b00, 8'd220, 8'h00, "rd220");
    single(1, 2'b10, 8'h10, 8'hEE, "mode10");
    single(0, 2'b11, 8'h10, 8'hEE, "mode11");
    single(0, 2'b00, 8'd199, 8'h00, "rd199");

    // Stray start from a non-granted master is ignored.
    mode[3:2]  = 2'b01;
    addr[15:8] = 8'h10;
    wdata[15:8] = 8'h00;
    req = 2'b01;
    wait_gnt(0, 1, "stray");
    start = 2'b10;
    @(negedge clk);
    start = 2'b00;
    check("stray_gnt_hold", 32'(gnt), 32'h1);
    check("stray_no_rdy", 32'(rdy), 0);
    run_txn(0, 2'b00, 8'h10, 8'h00, "stray_rd");
    req = 2'b00;
    @(negedge clk);

    // Reset asserted while a read response is on the bus.
    req = 2'b01;
    wait_gnt(0, 1, "rst_pre");
    run_txn(0, 2'b00, 8'h31, 8'h00, "rst_pre");
    rst_n = 1'b0;
    req   = 2'b00;
    mdl_rdata = 8'h00;
    #1;
    check("rst_mid_gnt", 32'(gnt), 0);
    check("rst_mid_rdy", 32'(rdy), 0);
    check("rst_mid_err", 32'(err), 0);
    check("rst_mid_rdata", 32'(rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    single(1, 2'b00, 8'h10, 8'h00, "post_rst");

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
